// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline hazard types and mult/div latency defaults
package mips_pkg;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef logic [1:0] tuse_t;
    typedef logic [1:0] tnew_t;
    typedef logic [4:0] reg_t;

    localparam tuse_t TUSE_NONE = 2'd3;

    // A source stalls when a pending writer of that register cannot forward in time.
    function automatic logic src_hazard(
        input reg_t  src,
        input tuse_t tuse,
        input reg_t  wa_e,
        input tnew_t tnew_e,
        input reg_t  wa_m,
        input tnew_t tnew_m
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == wa_e) && (tnew_e > tuse);
        hit_m = (src == wa_m) && (tnew_m > tuse);
        return (src != 5'd0) && (tuse != TUSE_NONE) && (hit_e || hit_m);
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - mult/div unit occupancy down-counter
module md_busy_timer
    import mips_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_LAT);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_LAT);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // A new start always reloads, so a start while busy restarts the count.
    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = is_div ? DIV_LOAD : MULT_LOAD;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = reset && (start || (cnt_q != 4'd0));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/bubble control with stall-cycle counter
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_d,
    input  logic [4:0]  rt_d,
    input  logic [1:0]  tuse_rs_d,
    input  logic [1:0]  tuse_rt_d,
    input  logic [4:0]  wa_e,
    input  logic [4:0]  wa_m,
    input  logic [1:0]  tnew_e,
    input  logic [1:0]  tnew_m,
    input  logic        md_use_d,
    input  logic        md_start_e,
    input  logic        md_div_e,
    input  logic        stall_clr,
    output logic        en_pc,
    output logic        en_d,
    output logic        clr_e,
    output logic        md_busy,
    output logic [31:0] stall_cycles
);

    logic        stall_rs;
    logic        stall_rt;
    logic        stall;
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;

    md_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (md_start_e),
        .is_div (md_div_e),
        .busy   (md_busy)
    );

    assign stall_rs = src_hazard(rs_d, tuse_rs_d, wa_e, tnew_e, wa_m, tnew_m);
    assign stall_rt = src_hazard(rt_d, tuse_rt_d, wa_e, tnew_e, wa_m, tnew_m);

    // Reset masks all hazards so the front end runs freely while held.
    assign stall = reset && (stall_rs || stall_rt || (md_use_d && md_busy));

    assign en_pc = ~stall;
    assign en_d  = ~stall;
    assign clr_e = stall;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_clr) begin
            stall_cycles_d = 32'd0;
        end else if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs_d, rt_d, wa_e, wa_m;
    logic [1:0]  tuse_rs_d, tuse_rt_d, tnew_e, tnew_m;
    logic        md_use_d, md_start_e, md_div_e, stall_clr;
    logic        en_pc, en_d, clr_e, md_busy;
    logic [31:0] stall_cycles;

    int          errors = 0;
    int          checks = 0;

    // Reference state: absolute cycle index and the last cycle the unit is occupied.
    int          cyc = 0;
    int          busy_last = -1;
    longint      m_cnt = 0;

    hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs_d         (rs_d),
        .rt_d         (rt_d),
        .tuse_rs_d    (tuse_rs_d),
        .tuse_rt_d    (tuse_rt_d),
        .wa_e         (wa_e),
        .wa_m         (wa_m),
        .tnew_e       (tnew_e),
        .tnew_m       (tnew_m),
        .md_use_d     (md_use_d),
        .md_start_e   (md_start_e),
        .md_div_e     (md_div_e),
        .stall_clr    (stall_clr),
        .en_pc        (en_pc),
        .en_d         (en_d),
        .clr_e        (clr_e),
        .md_busy      (md_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic haz(input logic [4:0] s, input logic [1:0] tuse);
        if (s == 5'd0 || tuse == 2'd3) return 1'b0;
        return (s == wa_e && tnew_e > tuse) || (s == wa_m && tnew_m > tuse);
    endfunction

    function automatic logic exp_busy();
        return reset && (md_start_e || (cyc <= busy_last));
    endfunction

    function automatic logic exp_stall();
        return reset && (haz(rs_d, tuse_rs_d) || haz(rt_d, tuse_rt_d) || (md_use_d && exp_busy()));
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc = 0;
            busy_last = -1;
            m_cnt = 0;
        end else begin
            logic s;
            s = exp_stall();
            if (md_start_e) busy_last = cyc + (md_div_e ? DIV_LAT : MULT_LAT);
            if (stall_clr) m_cnt = 0;
            else if (s && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            cyc++;
        end
    end

    always @(negedge clk) begin
        #3;
        chk("en_pc", 32'(en_pc), 32'(!exp_stall()));
        chk("en_d", 32'(en_d), 32'(!exp_stall()));
        chk("clr_e", 32'(clr_e), 32'(exp_stall()));
        chk("md_busy", 32'(md_busy), 32'(exp_busy()));
        chk("stall_cycles", stall_cycles, m_cnt[31:0]);
    end

    task automatic idle();
        rs_d = 0; rt_d = 0; wa_e = 0; wa_m = 0;
        tuse_rs_d = 2'd3; tuse_rt_d = 2'd3; tnew_e = 0; tnew_m = 0;
        md_use_d = 0; md_start_e = 0; md_div_e = 0; stall_clr = 0;
    endtask

    task automatic load_use();
        wa_e = 5'd8; tnew_e = 2'd2; rs_d = 5'd8; tuse_rs_d = 2'd1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        load_use();
        md_start_e = 1'b1;
        md_use_d = 1'b1;
        #3;
        chk("rst_en_pc", 32'(en_pc), 32'd1);
        chk("rst_clr_e", 32'(clr_e), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_cnt", stall_cycles, 32'd0);

        @(negedge clk); reset = 1'b1; idle();

        // Load-use: one bubble, then forwarding from M covers it.
        @(negedge clk); idle(); load_use();
        #3 chk("lu_en_pc", 32'(en_pc), 32'd0);
        chk("lu_clr_e", 32'(clr_e), 32'd1);
        @(negedge clk); idle(); rs_d = 8; tuse_rs_d = 1; wa_m = 8; tnew_m = 1;
        #3 chk("lu_next_en_pc", 32'(en_pc), 32'd1);
        chk("lu_cnt", stall_cycles, 32'd1);

        @(negedge clk); idle(); rs_d = 0; tuse_rs_d = 0; wa_e = 0; tnew_e = 2;
        #3 chk("zero_reg", 32'(en_pc), 32'd1);
        @(negedge clk); idle(); rt_d = 9; tuse_rt_d = 3; wa_e = 9; tnew_e = 2;
        #3 chk("tuse_none", 32'(en_pc), 32'd1);
        @(negedge clk); idle(); rt_d = 5; tuse_rt_d = 0; wa_m = 5; tnew_m = 1;
        #3 chk("rt_from_m", 32'(en_pc), 32'd0);
        @(negedge clk); idle(); rs_d = 7; tuse_rs_d = 1; wa_e = 7; tnew_e = 1;
        #3 chk("tnew_eq_tuse", 32'(en_pc), 32'd1);

        // Mult followed by a waiting mflo.
        @(negedge clk); idle(); stall_clr = 1;
        @(negedge clk); idle(); md_start_e = 1; md_use_d = 1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk); idle(); md_use_d = 1;
        end
        @(negedge clk); idle(); md_use_d = 1;
        #3 chk("mult_done_en_pc", 32'(en_pc), 32'd1);
        chk("mult_cnt", stall_cycles, 32'd6);

        // Div restarted by a mult three cycles in.
        @(negedge clk); idle(); md_start_e = 1; md_div_e = 1;
        @(negedge clk); idle();
        @(negedge clk); idle();
        @(negedge clk); idle(); md_start_e = 1;
        for (int i = 4; i <= 8; i++) begin
            @(negedge clk); idle();
        end
        #3 chk("restart_last_busy", 32'(md_busy), 32'd1);
        @(negedge clk); idle();
        #3 chk("restart_end", 32'(md_busy), 32'd0);

        // Reset mid-div, asserted between edges.
        @(negedge clk); idle(); md_start_e = 1; md_div_e = 1; md_use_d = 1;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); idle(); md_use_d = 1;
        end
        @(negedge clk); idle(); md_use_d = 1;
        #2 reset = 1'b0;
        #1 chk("rst_mid_busy", 32'(md_busy), 32'd0);
        chk("rst_mid_en_pc", 32'(en_pc), 32'd1);
        chk("rst_mid_cnt", stall_cycles, 32'd0);
        @(negedge clk); reset = 1'b1; idle(); md_use_d = 1;
        #3 chk("post_rst_en_pc", 32'(en_pc), 32'd1);

        // Saturation and clear-over-increment.
        @(negedge clk); idle(); load_use();
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        m_cnt = 64'hFFFF_FFFE;
        #1 release dut.stall_cycles_q;
        #2 chk("preload", stall_cycles, 32'hFFFF_FFFE);
        @(negedge clk); idle(); load_use();
        #3 chk("sat_reach", stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk); idle(); load_use();
        #3 chk("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        @(negedge clk); idle(); load_use(); stall_clr = 1;
        #3 chk("clr_cycle_stall", 32'(en_pc), 32'd0);
        @(negedge clk); idle();
        #3 chk("clr_wins", stall_cycles, 32'd0);

        @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Detects data hazards (Tuse/Tnew model) and multiply/divide-unit occupancy, and drives the PC and F/D enables and the D/E synchronous clear that inserts bubbles. Holds a cycle-accurate mult/div busy timer and a saturating stall-cycle counter for performance measurement. Sits beside the pipeline registers; all hazard inputs are pre-decoded by the stage decoders.

## Interface

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu issues in E
- DIV_LAT, 10, busy cycles after a div/divu issues in E

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset
- rs_d, rt_d  in  5  D-stage source register numbers
- tuse_rs_d, tuse_rt_d  in  2  cycles until D needs rs/rt; 3 = not used
- wa_e, wa_m  in  5  E/M destination register numbers; 0 = no write
- tnew_e  in  2  cycles until E result is available (0..2)
- tnew_m  in  2  cycles until M result is available (0..1)
- md_use_d  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- md_start_e  in  1  mult/div issuing in E this cycle
- md_div_e  in  1  qualifies md_start_e: 1 = div, 0 = mult
- stall_clr  in  1  synchronous clear of stall counter
- en_pc  out  1  PC register enable
- en_d  out  1  F/D register enable
- clr_e  out  1  D/E synchronous clear (bubble insert)
- md_busy  out  1  mult/div unit occupied
- stall_cycles  out  32  count of stalled cycles

## Operation

- Data hazard per source s in {rs, rt}:
  - stall_s = (s_d != 0) & ((s_d == wa_e & tnew_e > tuse_s_d) | (s_d == wa_m & tnew_m > tuse_s_d)).
  - tuse = 3 never stalls.
- Busy timer: 4-bit down-counter cnt.
  - md_start_e loads DIV_LAT if md_div_e, else MULT_LAT.
  - Otherwise decrements when nonzero.
  - Load wins over decrement; a start while busy restarts the count.
- md_busy = md_start_e | (cnt != 0).
- stall = stall_rs | stall_rt | (md_use_d & md_busy).
- Outputs: en_pc = en_d = ~stall; clr_e = stall.
- E/M/W always advance.
- stall_cycles:
  - stall_clr sets it to 0; clear wins over increment.
  - Otherwise +1 on each cycle with stall = 1.
  - Saturates at 0xFFFFFFFF.

## Timing

- Reset (reset = 0), asynchronous, effective immediately and for as long as held:
  - cnt = 0, stall_cycles = 0
  - en_pc = en_d = 1, clr_e = 0, md_busy = 0
  - Hazard inputs are ignored while reset is held.
- On release, operation starts at the first rising edge.
- Reset mid-multiply aborts the busy period.
- Stall outputs are combinational from inputs and cnt, valid in the same cycle; no added latency.
- Mult occupancy: md_busy is high in the start cycle and the MULT_LAT cycles after it (6 cycles total); DIV: 11 cycles.
- Load-use: a load in E (tnew_e = 2) with a consumer in D (tuse = 1) gives exactly 1 stall cycle. The next cycle the load is in M with tnew_m = 1, so no stall.

## Structure

- Shared package mips_pkg:
  - MULT_LAT and DIV_LAT defaults
  - TUSE_NONE = 3
  - 2-bit tuse/tnew type widths
- One sub-module: md_busy_timer. Contains the counter and md_busy; ports clk, reset, start, is_div, busy.
- Hazard comparison and stall counter stay in the top module.

## Test plan

- Load-use:
  - Stimulus: wa_e = 8, tnew_e = 2, rs_d = 8, tuse_rs_d = 1.
  - Response: en_pc = en_d = 0, clr_e = 1 for one cycle; stall_cycles = 1. Next cycle (wa_m = 8, tnew_m = 1, wa_e = 0) gives no stall.
- $0 and unused source:
  - rs_d = 0 with wa_e = 0, tnew_e = 2 → no stall.
  - rt_d = 9 with tuse_rt_d = 3, wa_e = 9 → no stall.
- Mult then mflo:
  - Stimulus: md_start_e = 1, md_div_e = 0, md_use_d held 1.
  - Response: stall for 6 cycles, then en_pc = 1; stall_cycles = 6.
- Div restart:
  - Stimulus: second md_start_e (mult) 3 cycles into a div.
  - Response: busy ends 5 cycles after the second start, not the div end.
- Reset mid-div:
  - Stimulus: assert reset = 0 between edges 4 cycles into a div.
  - Response: md_busy = 0 and en_pc = 1 immediately; stall_cycles = 0.
- Counter:
  - Preload via 2^32−1 stalled cycles (or force) → saturates at 0xFFFFFFFF.
  - stall_clr = 1 concurrent with stall → 0 next cycle.
